// File: rtl/fp_dot_seq_pkg.sv
// rtl/fp_dot_seq_pkg.sv - shared state encoding and default timing for FP MAC controllers
// Contents:
//   state_t        3-bit controller state type
//   S_IDLE..S_DONE state encodings
//   MAC_LAT_DEF    default MAC latency (input-valid cycle to result-valid cycle)
//   TMO_DEF        default extra cycles beyond MAC latency before a timeout
package fp_dot_seq_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE  = 3'd0;
    localparam state_t S_FETCH = 3'd1;
    localparam state_t S_ISSUE = 3'd2;
    localparam state_t S_WAIT  = 3'd3;
    localparam state_t S_DONE  = 3'd4;

    localparam int MAC_LAT_DEF = 16;
    localparam int TMO_DEF     = 8;

endpackage

// File: rtl/fp_dot_seq.sv
// rtl/fp_dot_seq.sv - sequential FP dot-product controller driving an external FP MAC
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   start, len                request a dot product of len (0..256) elements
//   busy, done, err, result   status, one-cycle completion pulse, timeout flag, IEEE-754 sum
//   mem_rd_en, mem_addr       operand-memory read strobe and element index
//   a_data, b_data            operands, valid the cycle after mem_rd_en
//   mac_in_valid, mac_a/b/c   MAC operand stream (c carries the running accumulator)
//   mac_res_valid, mac_res    MAC result stream (a*b+c)
module fp_dot_seq
    import fp_dot_seq_pkg::*;
#(
    parameter int MAC_LAT = MAC_LAT_DEF,
    parameter int TMO     = TMO_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [8:0]  len,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] result,
    output logic        mem_rd_en,
    output logic [7:0]  mem_addr,
    input  logic [31:0] a_data,
    input  logic [31:0] b_data,
    output logic        mac_in_valid,
    output logic [31:0] mac_a,
    output logic [31:0] mac_b,
    output logic [31:0] mac_c,
    input  logic        mac_res_valid,
    input  logic [31:0] mac_res
);

    localparam int LIMIT = MAC_LAT + TMO;
    localparam int WCW   = $clog2(LIMIT + 1);

    state_t         state;
    state_t         state_nxt;
    logic [8:0]     len_q;
    logic [8:0]     idx;
    logic [31:0]    acc;
    logic [WCW-1:0] wait_cnt;
    logic [31:0]    a_q;
    logic [31:0]    b_q;
    logic [31:0]    c_q;
    logic [31:0]    result_q;
    logic           err_q;
    logic           timeout;
    logic           last_elem;

    // The current WAIT cycle is the LIMIT-th one since the issue.
    assign timeout   = (wait_cnt == WCW'(LIMIT - 1));
    // idx is 9 bits so that len=256 is reached instead of wrapping to 0.
    assign last_elem = ((idx + 9'd1) == len_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (len == 9'd0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                if (mac_res_valid) begin
                    state_nxt = last_elem ? S_DONE : S_FETCH;
                end else if (timeout) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath registers. result is loaded on the edge that enters DONE
    // (with the value acc takes on that same edge) so that result is
    // already valid in the cycle done is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q    <= '0;
            idx      <= '0;
            acc      <= '0;
            wait_cnt <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        len_q <= len;
                        idx   <= '0;
                        acc   <= '0;
                        err_q <= 1'b0;
                        if (len == 9'd0) begin
                            result_q <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    wait_cnt <= '0;
                    a_q      <= a_data;
                    b_q      <= b_data;
                    c_q      <= acc;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + WCW'(1);
                    if (mac_res_valid) begin
                        acc <= mac_res;
                        idx <= idx + 9'd1;
                        if (last_elem) begin
                            result_q <= mac_res;
                        end
                    end else if (timeout) begin
                        err_q    <= 1'b1;
                        result_q <= acc;
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs. MAC operands pass through live in ISSUE and hold their
    // captured copies everywhere else.
    always_comb begin
        busy         = (state != S_IDLE);
        done         = (state == S_DONE);
        err          = err_q;
        result       = result_q;
        mem_rd_en    = (state == S_FETCH);
        mem_addr     = idx[7:0];
        mac_in_valid = (state == S_ISSUE);
        mac_a        = a_q;
        mac_b        = b_q;
        mac_c        = c_q;
        if (state == S_ISSUE) begin
            mac_a = a_data;
            mac_b = b_data;
            mac_c = acc;
        end
    end

endmodule

// File: doc/fp_dot_seq.md
FP_DOT_SEQ -- requirements
Module: fp_dot_seq

Interface
REQ-001 SHALL have parameter MAC_LAT, default 16, meaning the fixed MAC latency in cycles from the input-valid cycle to the result-valid cycle.
REQ-002 SHALL have parameter TMO, default 8, meaning the extra cycles beyond MAC_LAT before a timeout is declared.
REQ-003 SHALL have the following ports:
  clk  in  1  single clock; all logic on posedge; reset is synchronous and active-high
  rst  in  1  synchronous active-high reset
  start  in  1  request a dot product; sampled only in IDLE
  len  in  9  element count, 0..256; sampled with start
  busy  out  1  high in every state except IDLE
  done  out  1  one-cycle completion pulse
  err  out  1  timeout flag; valid with done
  result  out  32  IEEE-754 single accumulated sum; held until next start
  mem_rd_en  out  1  operand-memory read strobe
  mem_addr  out  8  element index
  a_data, b_data  in  32 each  operands, valid the cycle after mem_rd_en
  mac_in_valid  out  1  drives the a/b/c tvalid of the FP MAC
  mac_a, mac_b, mac_c  out  32 each  MAC operands; c is the running accumulator
  mac_res_valid  in  1  MAC result tvalid
  mac_res  in  32  MAC result tdata (a*b+c)

Function
REQ-004 SHALL implement states IDLE, FETCH, ISSUE, WAIT and DONE.
REQ-005 IDLE: on start=1 with len>0, SHALL latch len, clear acc and idx to 0, and go to FETCH.
REQ-006 IDLE: on start=1 with len=0, SHALL go to DONE with acc=0x00000000.
REQ-007 FETCH: SHALL hold mem_rd_en=1 and mem_addr=idx for one cycle, then go to ISSUE.
REQ-008 ISSUE: SHALL drive mac_in_valid=1 for exactly one cycle with mac_a=a_data, mac_b=b_data, mac_c=acc, clear the wait counter, then go to WAIT.
REQ-009 WAIT: on mac_res_valid=1, SHALL set acc<=mac_res and idx<=idx+1, then go to DONE if idx+1==len, else to FETCH.
REQ-010 WAIT: SHALL increment the wait counter each cycle; on reaching MAC_LAT+TMO without a result, SHALL set err=1 and go to DONE with acc unchanged.
REQ-011 DONE: SHALL assert done=1 for one cycle, load result<=acc, and return to IDLE.
REQ-012 SHALL make done/result/err visible exactly len*(MAC_LAT+2)+1 cycles after the start cycle for a nominal MAC, and 1 cycle after start for len=0.
REQ-013 SHALL ignore start in every state other than IDLE (no queuing).
REQ-014 SHALL ignore mac_res_valid in every state other than WAIT, so stale results after a reset or timeout are discarded.
REQ-015 SHALL clear err on the next accepted start.
REQ-016 SHALL drive mac_in_valid low and hold mac_a/b/c stable at their last values outside ISSUE.
REQ-017 SHALL perform no floating-point arithmetic internally; all arithmetic is delegated to the MAC.
REQ-018 SHALL size idx as 9 bits so that len=256 terminates without wrap-around.

Reset
REQ-019 On rst=1 at a clock edge, SHALL set state=IDLE and busy, done, err, mem_rd_en and mac_in_valid to 0.
REQ-020 On rst=1, SHALL set result, acc, idx, mem_addr, mac_a, mac_b, mac_c and the wait counter to 0.
REQ-021 Reset during any non-IDLE state SHALL abort the operation without generating a done pulse.
REQ-022 rst SHALL take priority over start when both are asserted in the same cycle.

Structure
REQ-023 SHALL place the state encoding (3-bit localparams) and the default MAC_LAT/TMO values in the shared fp package for reuse by other MAC controllers.
REQ-024 SHALL keep the wait counter/timeout as an internal process (no sub-module); the FP MAC IP is instantiated outside this block, alongside it in the top level.

Verification
REQ-025 a=[1.0,2.0,3.0] (0x3F800000, 0x40000000, 0x40400000), b=[4.0,5.0,6.0], len=3, real MAC with MAC_LAT=16 -> done in cycle 55, result=0x42000000 (32.0), err=0.
REQ-026 len=0 start -> done in cycle 1, result=0x00000000, no mem_rd_en or mac_in_valid ever asserted.
REQ-027 MAC stub that never asserts mac_res_valid, len=2 -> done at the 24th WAIT cycle of element 0, err=1, result=0.
REQ-028 start re-pulsed every cycle during a len=2 run -> exactly one done pulse and correct result; a second start accepted only after returning to IDLE.
REQ-029 rst asserted during WAIT of element 1, then a late mac_res_valid -> no done pulse, outputs zero, stray result ignored; the next len=1 run (a=2.0, b=0.5) gives 0x3F800000.
REQ-030 len=256 with all operands 1.0 -> mem_addr covers 0..255 once each, result=0x43800000 (256.0).
